instruction_fetch: RTL
======================

// Module: instruction_fetch
// PURPOSE
//  IF stage: owns the PC, issues word reads to the instruction memory, and drives
//  if_pc / if_instruction / if_no_op into if_id_reg. Applies hazard_control for the
//  IF stage and branch/jump redirects from signal_mux. Holds one skid entry so a
//  response arriving during a stall is never lost.
// PARAMETERS
//  ISA_WIDTH       32    instruction/PC width (matches `ISA_WIDTH)
//  PC_RESET        0     PC value after reset (byte address, word aligned)
//  MEM_ADDR_WIDTH  14    imem word-address width; imem_addr = pc[MEM_ADDR_WIDTH+1:2]
// PORTS
//  clk               in   1               clock, rising edge
//  rst_n             in   1               synchronous reset, active low
//  hazard_control    in   HAZD_CTL_WIDTH  NORMAL / RETRY / NO_OP for IF stage
//  pc_offset         in   1               take branch: target = id_pc + sext(imm)<<2
//  pc_overload       in   1               jump: target = pc_overload_addr
//  id_pc             in   ISA_WIDTH       pc+4 of instruction in ID
//  pc_offset_imm     in   16              branch immediate (signed, words)
//  pc_overload_addr  in   ISA_WIDTH       absolute jump target (byte)
//  imem_req          out  1               read request, registered
//  imem_addr         out  MEM_ADDR_WIDTH  word address, registered, stable while req&~ready
//  imem_ready        in   1               response valid this cycle
//  imem_rdata        in   ISA_WIDTH       instruction word, valid with imem_ready
//  if_pc             out  ISA_WIDTH       pc+4 of if_instruction
//  if_instruction    out  ISA_WIDTH       fetched instruction
//  if_no_op          out  1               1 = if_pc/if_instruction are a bubble
//  pc_misaligned     out  1               1-cycle pulse: redirect target had bits[1:0]!=0
//  stall_cnt         out  32              bubble-cycle counter (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst_n=0 at edge): pc=PC_RESET, state=BOOT, imem_req=0, imem_addr=0, if_pc=0,
//   if_instruction=0, if_no_op=1, pc_misaligned=0, skid empty, stall_cnt=0. Mid-wait
//   reset abandons the outstanding request; a later stray imem_ready is ignored in BOOT.
//  States: BOOT -> REQ (next cycle, imem_req=1, addr=pc). REQ: wait for imem_ready.
//   HOLD: skid full, imem_req=0. FLUSH: redirect taken with request outstanding;
//   wait for imem_ready, discard data, then REQ at new pc.
//  Priority per cycle: rst_n > redirect > hazard_control > imem_ready.
//  NORMAL, REQ, imem_ready=1: if_instruction<=rdata, if_pc<=pc+4, if_no_op<=0,
//   pc<=pc+4, next request issued next cycle (1 instr/cycle with zero-wait memory).
//  NORMAL, REQ, imem_ready=0: if_no_op<=1, outputs otherwise unchanged.
//  NORMAL, HOLD: present skid entry (if_no_op<=0), clear skid, -> REQ.
//  RETRY: if_* outputs and pc frozen; ready in this cycle -> data into skid, pc<=pc+4,
//   -> HOLD. NO_OP: as RETRY but if_no_op<=1; held entry still presented later.
//  Redirect (pc_offset|pc_overload, pc_overload wins): pc<=target & ~3, skid cleared,
//   if_no_op<=1; same-cycle imem_ready data discarded; -> FLUSH if request outstanding
//   and not completing this cycle, else REQ. Target bits[1:0]!=0 -> pc_misaligned=1.
//  Arithmetic: pc+4 and branch add wrap modulo 2^ISA_WIDTH; imem_addr wraps at 2^MEM_ADDR_WIDTH.
// CONFIGURATION
//  IF_STALL_CNT_EN defined: stall_cnt increments (saturating at 2^32-1) on every
//   cycle after reset where if_no_op is registered 1. Undefined: stall_cnt tied 0.
// TESTING
//  T1 reset, imem_ready=1 always -> imem_addr 0,1,2..; if_no_op=0 from 3rd cycle; if_pc 4,8,12.
//  T2 ready delayed 2 cycles on addr 3 -> addr held at 3, exactly 2 if_no_op bubbles, no skip.
//  T3 RETRY 3 cycles, ready during 1st -> outputs frozen; held instr appears first after
//   NORMAL; sequence has no loss or duplicate.
//  T4 pc_offset, id_pc=0x40, imm=0xFFFC -> next imem_addr=0x0C (pc=0x30); in-flight data dropped.
//  T5 pc_offset+pc_overload, addr=0x102 -> pc=0x100, imem_addr=0x40, pc_misaligned one pulse.
//  T6 rst_n=0 during FLUSH -> all outputs reset at that edge; refetch from PC_RESET;
//   with IF_STALL_CNT_EN, stall_cnt restarts at 0.

Source files
------------

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch
// Description : IF stage. Owns the PC, issues registered word reads to the
//               instruction memory and presents pc+4 / instruction / bubble
//               flag to the IF/ID register. Applies the IF-stage hazard
//               control and branch/jump redirects, and keeps one skid entry
//               so a response arriving while the stage is stalled is held
//               rather than dropped.
// Options     : IF_STALL_CNT_EN - when defined, stall_cnt counts registered
//               bubble cycles (saturating); otherwise stall_cnt is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
  parameter int ISA_WIDTH      = 32,
  parameter int PC_RESET       = 0,
  parameter int MEM_ADDR_WIDTH = 14,
  parameter int HAZD_CTL_WIDTH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [HAZD_CTL_WIDTH-1:0] hazard_control,
  input  logic                      pc_offset,
  input  logic                      pc_overload,
  input  logic [ISA_WIDTH-1:0]      id_pc,
  input  logic [15:0]               pc_offset_imm,
  input  logic [ISA_WIDTH-1:0]      pc_overload_addr,
  output logic                      imem_req,
  output logic [MEM_ADDR_WIDTH-1:0] imem_addr,
  input  logic                      imem_ready,
  input  logic [ISA_WIDTH-1:0]      imem_rdata,
  output logic [ISA_WIDTH-1:0]      if_pc,
  output logic [ISA_WIDTH-1:0]      if_instruction,
  output logic                      if_no_op,
  output logic                      pc_misaligned,
  output logic [31:0]               stall_cnt
);

  // Hazard-control encoding for the IF stage. Any code other than NORMAL or
  // RETRY is treated as NO_OP (freeze plus bubble), the conservative choice.
  localparam logic [HAZD_CTL_WIDTH-1:0] c_HZ_NORMAL = HAZD_CTL_WIDTH'(0);
  localparam logic [HAZD_CTL_WIDTH-1:0] c_HZ_RETRY  = HAZD_CTL_WIDTH'(1);
  localparam logic [ISA_WIDTH-1:0]      c_PC_RESET  = ISA_WIDTH'(PC_RESET);

  // BOOT : first cycle after reset, no request yet.
  // REQ  : request outstanding at r_pc, waiting for imem_ready.
  // HOLD : skid holds a fetched word, no request outstanding.
  // FLUSH: request outstanding for a path that was redirected away from;
  //        its response is waited for and thrown away.
  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_REQ   = 2'd1,
    S_HOLD  = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t                    r_state;
  logic [ISA_WIDTH-1:0]      r_pc;
  logic                      r_imem_req;
  logic [MEM_ADDR_WIDTH-1:0] r_imem_addr;
  logic [ISA_WIDTH-1:0]      r_if_pc;
  logic [ISA_WIDTH-1:0]      r_if_instruction;
  logic                      r_if_no_op;
  logic                      r_pc_misaligned;
  logic                      r_skid_valid;
  logic [ISA_WIDTH-1:0]      r_skid_pc;
  logic [ISA_WIDTH-1:0]      r_skid_instr;

  logic                      w_redirect;
  logic [ISA_WIDTH-1:0]      w_imm_ext;
  logic [ISA_WIDTH-1:0]      w_branch_target;
  logic [ISA_WIDTH-1:0]      w_target;
  logic [ISA_WIDTH-1:0]      w_target_aligned;
  logic [ISA_WIDTH-1:0]      w_pc_plus4;
  logic                      w_outstanding;
  logic                      w_hz_normal;
  logic                      w_hz_retry;

  // Redirect target: a jump overrides a branch; branch immediates are words.
  always_comb begin
    w_redirect       = pc_offset | pc_overload;
    w_imm_ext        = {{(ISA_WIDTH-16){pc_offset_imm[15]}}, pc_offset_imm};
    w_branch_target  = id_pc + {w_imm_ext[ISA_WIDTH-3:0], 2'b00};
    w_target         = pc_overload ? pc_overload_addr : w_branch_target;
    w_target_aligned = {w_target[ISA_WIDTH-1:2], 2'b00};
    w_pc_plus4       = r_pc + ISA_WIDTH'(4);
    w_outstanding    = (r_state == S_REQ) || (r_state == S_FLUSH);
    w_hz_normal      = (hazard_control == c_HZ_NORMAL);
    w_hz_retry       = (hazard_control == c_HZ_RETRY);
  end

  // Fetch sequencer: redirect beats hazard control, which beats a response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state          <= S_BOOT;
      r_pc             <= c_PC_RESET;
      r_imem_req       <= 1'b0;
      r_imem_addr      <= '0;
      r_if_pc          <= '0;
      r_if_instruction <= '0;
      r_if_no_op       <= 1'b1;
      r_pc_misaligned  <= 1'b0;
      r_skid_valid     <= 1'b0;
      r_skid_pc        <= '0;
      r_skid_instr     <= '0;
    end else begin
      r_pc_misaligned <= 1'b0;
      if (w_redirect) begin
        // Any fetched or skidded word belongs to the abandoned path.
        r_pc            <= w_target_aligned;
        r_skid_valid    <= 1'b0;
        r_if_no_op      <= 1'b1;
        r_pc_misaligned <= |w_target[1:0];
        if (w_outstanding && !imem_ready) begin
          // Address stays put until the stale response drains.
          r_state <= S_FLUSH;
        end else begin
          r_state     <= S_REQ;
          r_imem_req  <= 1'b1;
          r_imem_addr <= w_target[MEM_ADDR_WIDTH+1:2];
        end
      end else begin
        case (r_state)
          S_BOOT: begin
            // Any imem_ready here belongs to a request abandoned by reset.
            r_state     <= S_REQ;
            r_imem_req  <= 1'b1;
            r_imem_addr <= r_pc[MEM_ADDR_WIDTH+1:2];
          end

          S_REQ: begin
            if (w_hz_normal) begin
              if (imem_ready) begin
                r_if_instruction <= imem_rdata;
                r_if_pc          <= w_pc_plus4;
                r_if_no_op       <= 1'b0;
                r_pc             <= w_pc_plus4;
                r_imem_addr      <= w_pc_plus4[MEM_ADDR_WIDTH+1:2];
              end else begin
                r_if_no_op <= 1'b1;
              end
            end else begin
              // Stalled: outputs frozen; a response is parked in the skid.
              if (!w_hz_retry) begin
                r_if_no_op <= 1'b1;
              end
              if (imem_ready) begin
                r_skid_valid <= 1'b1;
                r_skid_instr <= imem_rdata;
                r_skid_pc    <= w_pc_plus4;
                r_pc         <= w_pc_plus4;
                r_imem_req   <= 1'b0;
                r_state      <= S_HOLD;
              end
            end
          end

          S_HOLD: begin
            if (w_hz_normal) begin
              // Present the parked word, then resume fetching at r_pc.
              r_if_instruction <= r_skid_instr;
              r_if_pc          <= r_skid_pc;
              r_if_no_op       <= ~r_skid_valid;
              r_skid_valid     <= 1'b0;
              r_state          <= S_REQ;
              r_imem_req       <= 1'b1;
              r_imem_addr      <= r_pc[MEM_ADDR_WIDTH+1:2];
            end else if (!w_hz_retry) begin
              r_if_no_op <= 1'b1;
            end
          end

          S_FLUSH: begin
            if (!w_hz_retry) begin
              r_if_no_op <= 1'b1;
            end
            if (imem_ready) begin
              // Stale word dropped; request the redirected PC next cycle.
              r_state     <= S_REQ;
              r_imem_req  <= 1'b1;
              r_imem_addr <= r_pc[MEM_ADDR_WIDTH+1:2];
            end
          end

          default: begin
            r_state <= S_BOOT;
          end
        endcase
      end
    end
  end

`ifdef IF_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Count cycles in which the registered output is a bubble, saturating.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (r_if_no_op && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = 32'd0;
`endif

  assign imem_req       = r_imem_req;
  assign imem_addr      = r_imem_addr;
  assign if_pc          = r_if_pc;
  assign if_instruction = r_if_instruction;
  assign if_no_op       = r_if_no_op;
  assign pc_misaligned  = r_pc_misaligned;

endmodule
`default_nettype wire
